// File: rtl/bus_mem_responder_if.sv
// System bus between the CPU core's bus controller (master) and a memory
// responder (slave). Signal names follow the core's BUS_* naming.
interface bus_mem_responder_if;
    logic [31:0] BUS_addr;
    logic [31:0] BUS_wdata;
    logic        BUS_mode;
    logic        BUS_valid;
    logic        BUS_rready;
    logic        BUS_wready;
    logic        BUS_rvalid;
    logic [31:0] BUS_rdata;

    modport master (
        output BUS_addr, BUS_wdata, BUS_mode, BUS_valid, BUS_rready,
        input  BUS_wready, BUS_rvalid, BUS_rdata
    );

    modport slave (
        input  BUS_addr, BUS_wdata, BUS_mode, BUS_valid, BUS_rready,
        output BUS_wready, BUS_rvalid, BUS_rdata
    );
endinterface

// File: rtl/bus_mem_responder.sv
// Word-addressed memory acting as the responder on the core's system bus.
// One request at a time, programmable read/write wait states, and a
// one-cycle access_err pulse when an access completes outside the array.
module bus_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned WR_WAIT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    bus_mem_responder_if.slave  bus,
    output logic                access_err
);

    localparam int unsigned DEPTH     = 32'd1 << DEPTH_LOG2;
    localparam logic [3:0]  RD_WAIT_C = 4'(RD_WAIT);
    localparam logic [3:0]  WR_WAIT_C = 4'(WR_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WACK  = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Word address is in range when every bit above the array index is zero.
    function automatic logic word_in_range(input logic [29:0] waddr);
        return (waddr >> DEPTH_LOG2) == 30'd0;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mode_q, mode_d;
    logic        wready_q, wready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mem_we_s;
    logic        in_range_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic [1:0]  unused_addr_lsb_s;

    // Contents are deliberately never reset so data survives rst_n.
    logic [31:0] mem_r [DEPTH];

    assign unused_addr_lsb_s = bus.BUS_addr[1:0];
    assign idx_s             = addr_q[DEPTH_LOG2-1:0];
    assign in_range_s        = word_in_range(addr_q);

    assign bus.BUS_wready = wready_q;
    assign bus.BUS_rvalid = rvalid_q;
    assign bus.BUS_rdata  = rdata_q;
    assign access_err     = err_q;

    // Next-state and response logic for the request FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mode_d   = mode_q;
        wready_d = 1'b0;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.BUS_valid) begin
                    addr_d  = bus.BUS_addr[31:2];
                    wdata_d = bus.BUS_wdata;
                    mode_d  = bus.BUS_mode;
                    cnt_d   = bus.BUS_mode ? WR_WAIT_C : RD_WAIT_C;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // An initiator that withdraws mid-wait gets no response at all.
                if (!bus.BUS_valid) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (mode_q) begin
                    mem_we_s = in_range_s;
                    wready_d = 1'b1;
                    err_d    = ~in_range_s;
                    state_d  = ST_WACK;
                end else begin
                    rvalid_d = 1'b1;
                    rdata_d  = in_range_s ? mem_r[idx_s] : 32'd0;
                    state_d  = ST_RDATA;
                end
            end
            ST_WACK: begin
                state_d = ST_DONE;
            end
            ST_RDATA: begin
                // Only the read handshake ends the read; BUS_valid is ignored here.
                if (bus.BUS_rready) begin
                    rvalid_d = 1'b0;
                    rdata_d  = 32'd0;
                    err_d    = ~in_range_s;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_DONE: begin
                // Wait for BUS_valid to drop so a held request is not re-accepted.
                if (!bus.BUS_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rvalid_d = 1'b0;
                rdata_d  = 32'd0;
            end
        endcase
    end

    // FSM state, captured request and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 30'd0;
            wdata_q  <= 32'd0;
            mode_q   <= 1'b0;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mode_q   <= mode_d;
            wready_q <= wready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Memory array write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= wdata_q;
        end
    end

endmodule
